// File: rtl/seven_seg_mux_ndigit.sv
// Multiplexed common-anode 7-segment driver for an N-digit packed BCD bus.
// Scans one digit per refresh slot with blanking and a once-per-scan input snapshot.
module seven_seg_mux_ndigit #(
  parameter int N_DIGITS     = 3,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] BCD,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic                  lz_blank,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   anode_n
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CW-1:0]           cnt;
  logic [SW-1:0]           sel;
  logic [4*N_DIGITS-1:0]   snap;
  logic                    first;

  logic                    tick;
  logic                    last_sel;
  logic [3:0]              digit;
  logic                    dp_sel;
  logic [N_DIGITS-1:0]     anode_sel;
  logic                    upper_zero;
  logic                    digit_blank;
  logic                    in_blank_window;
  logic [N_DIGITS-1:0]     anode_next;
  logic [6:0]              seg_next;
  logic                    dp_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  assign tick     = (cnt == CW'(REFRESH_DIV - 1));
  assign last_sel = (sel == SW'(N_DIGITS - 1));

  always_comb begin
    digit       = 4'd0;
    dp_sel      = 1'b0;
    anode_sel   = '1;
    upper_zero  = 1'b1;
    digit_blank = 1'b0;
    // Walk from the most significant digit down so upper_zero covers digits i..N-1.
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (snap[4*i +: 4] == 4'd0);
      if (sel == SW'(i)) begin
        digit        = snap[4*i +: 4];
        dp_sel       = dp_mask[i];
        anode_sel[i] = 1'b0;
        digit_blank  = lz_blank && (i != 0) && upper_zero;
      end
    end
    in_blank_window = (cnt < CW'(BLANK_CYCLES));
    anode_next      = (in_blank_window || digit_blank) ? '1 : anode_sel;
    seg_next        = digit_blank ? 7'h7F : decode(digit);
    dp_next         = (anode_next == '1) ? 1'b1 : ~dp_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      sel     <= '0;
      snap    <= '0;
      first   <= 1'b1;
      seg_n   <= 7'h7F;
      dp_n    <= 1'b1;
      anode_n <= '1;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        sel <= last_sel ? '0 : sel + SW'(1);
      end
      // Reloading only at the end of a full scan keeps a counter carry from tearing the display.
      if (first || (tick && last_sel)) begin
        snap <= BCD;
      end
      first   <= 1'b0;
      seg_n   <= seg_next;
      dp_n    <= dp_next;
      anode_n <= anode_next;
    end
  end

endmodule
